l15_transducer_arb: RTL
=======================

Name: l15_transducer_arb

Overview:
Two-requester arbiter in front of the L1.5 transducer request/response interface. Requester 0 is the core transducer and requester 1 is an auxiliary engine (DMA/accelerator); both share a single L1.5 instance. The arbiter grants the request port round-robin and holds each grant until the L1.5 acks. It tags each request with the requester index in threadid, routes unicast responses back by threadid, and broadcasts invalidation/interrupt responses to both requesters. Sits between the transducers and the l15 instance, inside the tile.

Parameters:
MAX_OUT, 4, max outstanding requests per requester (1..15)
BCAST_TYPE_A, 4'b0011, returntype broadcast to both requesters (invalidation)
BCAST_TYPE_B, 4'b0111, second broadcast returntype (interrupt)

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
rN_val  in  1  requester N (N=0,1) request valid; held stable until rN_ack
rN_rqtype  in  5  request type
rN_nc  in  1  non-cacheable
rN_size  in  3  access size
rN_address  in  40  address
rN_data  in  64  store data
rN_ack  out  1  one-cycle pulse: request accepted by L1.5
rN_rsp_val  out  1  response valid to requester N
rN_rsp_ack  in  1  requester N consumed response
arb_l15_val  out  1  to transducer_l15_val
arb_l15_rqtype/nc/size/address/data  out  5/1/3/40/64  muxed request fields
arb_l15_threadid  out  1  granted requester index
l15_arb_ack  in  1  from l15_transducer_ack
l15_arb_rsp_val  in  1  from l15_transducer_val
l15_arb_returntype  in  4  from l15_transducer_returntype
l15_arb_threadid  in  1  from l15_transducer_threadid
arb_l15_req_ack  out  1  to transducer_l15_req_ack
rN_outstanding  out  4  outstanding count, observability

Behaviour:
- Reset (async, rst=1): grant FSM in IDLE, priority pointer=0, response FSM in R_IDLE, broadcast-done flags=0, counters=0. All outputs are 0.
- Eligibility: eligN = rN_val & (rN_outstanding < MAX_OUT).
- Grant FSM states IDLE and HOLD:
  - IDLE: if any elig, grant the requester selected by the pointer when both are eligible, otherwise the single eligible one. Latch grant id and go to HOLD. No output in this cycle (1-cycle arbitration latency).
  - HOLD: arb_l15_val=1 and the request fields are muxed from the granted requester; threadid=grant id.
  - On l15_arb_ack: pulse rG_ack the same cycle; counter G +1; pointer = ~G; go to IDLE.
  - The grant is never revoked while in HOLD, even if rG_val drops (a protocol violation flagged by assertion).
- Response FSM states R_IDLE and R_BCAST:
  - Unicast (returntype not in {A,B}): rT_rsp_val = l15_arb_rsp_val where T = l15_arb_threadid. arb_l15_req_ack = rT_rsp_ack, combinational. On the ack cycle, counter T -1; the counter saturates at 0 (assertion).
  - Broadcast: in R_IDLE, seeing l15_arb_rsp_val with a broadcast type moves to R_BCAST.
  - R_BCAST: rN_rsp_val=1 for every N whose done flag is 0; rN_rsp_ack sets doneN. Once both flags are set, or both acks arrive in the same cycle, pulse arb_l15_req_ack for 1 cycle, clear the flags, and return to R_IDLE. Counters are unchanged on broadcast.
- Simultaneous events: when request ack and unicast response ack hit the same counter in the same cycle, the net change is 0.
- Reset mid-operation: all state clears immediately. The in-flight request is dropped; the system resets the L1.5 together with the arbiter.
- Request and response paths are independent; a grant can complete while a broadcast is pending.

Test Plan:
1. Only r0_val=1 (addr 0x00_1000_0040) and l15 acks 3 cycles after arb_l15_val -> arb_l15_threadid=0, fields match r0, r0_ack pulses once, r0_outstanding=1.
2. r0_val and r1_val both asserted continuously, L1.5 acks each request 1 cycle after val -> grants alternate 0,1,0,1; every grant is separated by an IDLE cycle; no requester waits more than one grant.
3. MAX_OUT=2: r1 issues 2 requests with no responses -> r1 is no longer granted while r0 keeps being granted. A unicast response with threadid=1, acked -> r1_outstanding=1 and r1 is eligible again.
4. Broadcast returntype 4'b0011: r0_rsp_ack at cycle 1, r1_rsp_ack at cycle 4 -> r0_rsp_val drops after cycle 1, r1_rsp_val stays high through cycle 4, arb_l15_req_ack pulses once in cycle 4, counters unchanged.
5. r0 request ack and r0 unicast response ack in the same cycle with r0_outstanding=1 -> count stays 1.
6. rst asserted while in HOLD and R_BCAST -> all outputs 0 asynchronously, pointer=0. After release, the first grant goes to r0 when both requesters request.

Source files
------------

// File: rtl/l15_transducer_arb_if.sv
// Request/response bundle between the two transducers, the arbiter and the L1.5.
// The arbiter takes the slave view; the environment (transducers + L1.5) takes the master view.
interface l15_transducer_arb_if;
   // Valid/ready rule for every channel: a valid is held with its payload stable
   // until the matching ack is seen high in the same cycle; ack without valid means nothing.
   logic        r0_val,      r1_val;
   logic [4:0]  r0_rqtype,   r1_rqtype;
   logic        r0_nc,       r1_nc;
   logic [2:0]  r0_size,     r1_size;
   logic [39:0] r0_address,  r1_address;
   logic [63:0] r0_data,     r1_data;
   logic        r0_ack,      r1_ack;
   logic        r0_rsp_val,  r1_rsp_val;
   logic        r0_rsp_ack,  r1_rsp_ack;
   logic [3:0]  r0_outstanding, r1_outstanding;

   logic        arb_l15_val;
   logic [4:0]  arb_l15_rqtype;
   logic        arb_l15_nc;
   logic [2:0]  arb_l15_size;
   logic [39:0] arb_l15_address;
   logic [63:0] arb_l15_data;
   logic        arb_l15_threadid;
   logic        l15_arb_ack;
   logic        l15_arb_rsp_val;
   logic [3:0]  l15_arb_returntype;
   logic        l15_arb_threadid;
   logic        arb_l15_req_ack;

   modport slave (
      input  r0_val, r0_rqtype, r0_nc, r0_size, r0_address, r0_data, r0_rsp_ack,
      input  r1_val, r1_rqtype, r1_nc, r1_size, r1_address, r1_data, r1_rsp_ack,
      input  l15_arb_ack, l15_arb_rsp_val, l15_arb_returntype, l15_arb_threadid,
      output r0_ack, r0_rsp_val, r0_outstanding, r1_ack, r1_rsp_val, r1_outstanding,
      output arb_l15_val, arb_l15_rqtype, arb_l15_nc, arb_l15_size, arb_l15_address,
      output arb_l15_data, arb_l15_threadid, arb_l15_req_ack
   );

   modport master (
      output r0_val, r0_rqtype, r0_nc, r0_size, r0_address, r0_data, r0_rsp_ack,
      output r1_val, r1_rqtype, r1_nc, r1_size, r1_address, r1_data, r1_rsp_ack,
      output l15_arb_ack, l15_arb_rsp_val, l15_arb_returntype, l15_arb_threadid,
      input  r0_ack, r0_rsp_val, r0_outstanding, r1_ack, r1_rsp_val, r1_outstanding,
      input  arb_l15_val, arb_l15_rqtype, arb_l15_nc, arb_l15_size, arb_l15_address,
      input  arb_l15_data, arb_l15_threadid, arb_l15_req_ack
   );
endinterface

// File: rtl/l15_transducer_arb.sv
// Round-robin two-requester arbiter in front of one L1.5 transducer port, with
// threadid-based response routing and broadcast of invalidation/interrupt responses.
module l15_transducer_arb #(
   parameter int unsigned MAX_OUT      = 4,
   parameter logic [3:0]  BCAST_TYPE_A = 4'b0011,
   parameter logic [3:0]  BCAST_TYPE_B = 4'b0111
) (
   input  logic                 clk,
   input  logic                 rst,
   l15_transducer_arb_if.slave  bus,
   output logic                 dbg_gnt_state_o,
   output logic                 dbg_rsp_state_o,
   output logic                 dbg_ptr_o
);
   typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} gnt_state_e;
   typedef enum logic {R_IDLE = 1'b0, R_BCAST = 1'b1} rsp_state_e;

   localparam logic [3:0] MAX_OUT_C = 4'(MAX_OUT);

   gnt_state_e gnt_state_q, gnt_state_d;
   rsp_state_e rsp_state_q, rsp_state_d;
   logic       gnt_id_q, gnt_id_d;
   logic       ptr_q, ptr_d;
   logic       done0_q, done0_d, done1_q, done1_d;
   logic [3:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;
   logic       elig0, elig1, is_bcast;
   logic       inc0, inc1, dec0, dec1;

   assign elig0    = bus.r0_val & (cnt0_q < MAX_OUT_C);
   assign elig1    = bus.r1_val & (cnt1_q < MAX_OUT_C);
   assign is_bcast = (bus.l15_arb_returntype == BCAST_TYPE_A) ||
                     (bus.l15_arb_returntype == BCAST_TYPE_B);

   always_comb begin
      gnt_state_d          = gnt_state_q;
      gnt_id_d             = gnt_id_q;
      ptr_d                = ptr_q;
      inc0                 = 1'b0;
      inc1                 = 1'b0;
      bus.r0_ack           = 1'b0;
      bus.r1_ack           = 1'b0;
      bus.arb_l15_val      = 1'b0;
      bus.arb_l15_rqtype   = '0;
      bus.arb_l15_nc       = 1'b0;
      bus.arb_l15_size     = '0;
      bus.arb_l15_address  = '0;
      bus.arb_l15_data     = '0;
      bus.arb_l15_threadid = 1'b0;
      case (gnt_state_q)
         IDLE: begin
            if (elig0 | elig1) begin
               gnt_id_d    = (elig0 & elig1) ? ptr_q : elig1;
               gnt_state_d = HOLD;
            end
         end
         HOLD: begin
            bus.arb_l15_val      = 1'b1;
            bus.arb_l15_threadid = gnt_id_q;
            bus.arb_l15_rqtype   = gnt_id_q ? bus.r1_rqtype  : bus.r0_rqtype;
            bus.arb_l15_nc       = gnt_id_q ? bus.r1_nc      : bus.r0_nc;
            bus.arb_l15_size     = gnt_id_q ? bus.r1_size    : bus.r0_size;
            bus.arb_l15_address  = gnt_id_q ? bus.r1_address : bus.r0_address;
            bus.arb_l15_data     = gnt_id_q ? bus.r1_data    : bus.r0_data;
            if (bus.l15_arb_ack) begin
               bus.r0_ack  = ~gnt_id_q;
               bus.r1_ack  = gnt_id_q;
               inc0        = ~gnt_id_q;
               inc1        = gnt_id_q;
               ptr_d       = ~gnt_id_q;
               gnt_state_d = IDLE;
            end
         end
         default: gnt_state_d = IDLE;
      endcase
   end

   always_comb begin
      rsp_state_d         = rsp_state_q;
      done0_d             = done0_q;
      done1_d             = done1_q;
      dec0                = 1'b0;
      dec1                = 1'b0;
      bus.r0_rsp_val      = 1'b0;
      bus.r1_rsp_val      = 1'b0;
      bus.arb_l15_req_ack = 1'b0;
      case (rsp_state_q)
         R_IDLE: begin
            if (bus.l15_arb_rsp_val) begin
               if (is_bcast) begin
                  rsp_state_d = R_BCAST;
               end else if (bus.l15_arb_threadid) begin
                  bus.r1_rsp_val      = 1'b1;
                  bus.arb_l15_req_ack = bus.r1_rsp_ack;
                  dec1                = bus.r1_rsp_ack;
               end else begin
                  bus.r0_rsp_val      = 1'b1;
                  bus.arb_l15_req_ack = bus.r0_rsp_ack;
                  dec0                = bus.r0_rsp_ack;
               end
            end
         end
         R_BCAST: begin
            // Each requester sees the broadcast until it acks; L1.5 is released once both have.
            bus.r0_rsp_val = ~done0_q;
            bus.r1_rsp_val = ~done1_q;
            done0_d        = done0_q | bus.r0_rsp_ack;
            done1_d        = done1_q | bus.r1_rsp_ack;
            if (done0_d & done1_d) begin
               bus.arb_l15_req_ack = 1'b1;
               done0_d             = 1'b0;
               done1_d             = 1'b0;
               rsp_state_d         = R_IDLE;
            end
         end
         default: rsp_state_d = R_IDLE;
      endcase
   end

   function automatic logic [3:0] cnt_next(input logic [3:0] c, input logic inc,
                                           input logic dec);
      logic [3:0] n;
      n = c;
      case ({inc, dec})
         2'b10:   n = c + 4'd1;
         2'b01:   n = (c == 4'd0) ? c : c - 4'd1;
         default: n = c;
      endcase
      return n;
   endfunction

   assign cnt0_d = cnt_next(cnt0_q, inc0, dec0);
   assign cnt1_d = cnt_next(cnt1_q, inc1, dec1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         gnt_state_q <= IDLE;
         rsp_state_q <= R_IDLE;
         gnt_id_q    <= 1'b0;
         ptr_q       <= 1'b0;
         done0_q     <= 1'b0;
         done1_q     <= 1'b0;
         cnt0_q      <= '0;
         cnt1_q      <= '0;
      end else begin
         gnt_state_q <= gnt_state_d;
         rsp_state_q <= rsp_state_d;
         gnt_id_q    <= gnt_id_d;
         ptr_q       <= ptr_d;
         done0_q     <= done0_d;
         done1_q     <= done1_d;
         cnt0_q      <= cnt0_d;
         cnt1_q      <= cnt1_d;
      end
   end

   assign bus.r0_outstanding = cnt0_q;
   assign bus.r1_outstanding = cnt1_q;
   assign dbg_gnt_state_o    = gnt_state_q;
   assign dbg_rsp_state_o    = rsp_state_q;
   assign dbg_ptr_o          = ptr_q;

   // A granted requester must keep its request up until the L1.5 takes it.
   a_hold_val_stable: assert property (@(posedge clk) disable iff (rst)
      (gnt_state_q == HOLD) |-> (gnt_id_q ? bus.r1_val : bus.r0_val));
   a_cnt0_no_underflow: assert property (@(posedge clk) disable iff (rst)
      (dec0 && !inc0) |-> (cnt0_q != 4'd0));
   a_cnt1_no_underflow: assert property (@(posedge clk) disable iff (rst)
      (dec1 && !inc1) |-> (cnt1_q != 4'd0));
endmodule
